// File: rtl/audio_sample_strobe_gen.sv
// Audio sample strobe generator for the HDMI pixel-clock domain.
// A fractional (Bresenham) accumulator adds SAMPLE_RATE each clock and
// subtracts the current pixel-clock frequency on wrap, so the long-term
// strobe rate is exactly SAMPLE_RATE. The 192-frame IEC60958 block
// position is tracked alongside each strobe.
module audio_sample_strobe_gen #(
  parameter int SAMPLE_RATE = 48000,
  parameter int FREQ_W      = 28,
  parameter int BLOCK_LEN   = 192
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [FREQ_W-1:0] freq_hz,
  output logic              audio_sample,
  output logic [7:0]        sample_idx,
  output logic              block_start,
  output logic              freq_err
);

  localparam logic [FREQ_W:0]   SR_EXT    = (FREQ_W+1)'(SAMPLE_RATE);
  localparam logic [FREQ_W-1:0] ERR_LIMIT = FREQ_W'(2 * SAMPLE_RATE);
  localparam logic [7:0]        IDX_LAST  = 8'(BLOCK_LEN - 1);

  // State registers
  logic [FREQ_W-1:0] freq_reg_r;
  logic [FREQ_W-1:0] acc_r;
  logic [7:0]        idx_cnt_r;
  logic              first_strobe_r;
  logic              freq_err_r;
  logic              audio_sample_r;
  logic [7:0]        sample_idx_r;
  logic              block_start_r;

  // Combinational next-state signals
  logic              freq_chg_s;
  logic              run_s;
  logic [FREQ_W:0]   acc_sum_s;
  logic              wrap_s;
  logic [FREQ_W-1:0] acc_nxt_s;
  logic [7:0]        cur_idx_s;
  logic [7:0]        idx_nxt_s;
  logic              first_nxt_s;
  logic              freq_err_nxt_s;

  // Accumulator step: a frequency change or an unusable frequency restarts
  // the phase at zero; otherwise add the sample rate and wrap modulo freq.
  always_comb begin
    freq_chg_s     = (freq_hz != freq_reg_r);
    run_s          = enable && !freq_err_r && !freq_chg_s;
    acc_sum_s      = {1'b0, acc_r} + SR_EXT;
    wrap_s         = run_s && (acc_sum_s >= {1'b0, freq_reg_r});
    freq_err_nxt_s = (freq_reg_r < ERR_LIMIT);
    if (freq_chg_s) begin
      acc_nxt_s = {FREQ_W{1'b0}};
    end else if (!enable || freq_err_r) begin
      acc_nxt_s = {FREQ_W{1'b0}};
    end else if (wrap_s) begin
      // Modular subtraction on the low bits; the true difference fits.
      acc_nxt_s = acc_sum_s[FREQ_W-1:0] - freq_reg_r;
    end else begin
      acc_nxt_s = acc_sum_s[FREQ_W-1:0];
    end
  end

  // Frame-index bookkeeping: the counter names the frame of the next strobe
  // and restarts at zero whenever generation is disabled.
  always_comb begin
    if (first_strobe_r) begin
      cur_idx_s = 8'd0;
    end else begin
      cur_idx_s = idx_cnt_r;
    end
    if (!enable) begin
      idx_nxt_s   = 8'd0;
      first_nxt_s = 1'b1;
    end else if (wrap_s) begin
      if (cur_idx_s == IDX_LAST) begin
        idx_nxt_s = 8'd0;
      end else begin
        idx_nxt_s = cur_idx_s + 8'd1;
      end
      first_nxt_s = 1'b0;
    end else begin
      idx_nxt_s   = idx_cnt_r;
      first_nxt_s = first_strobe_r;
    end
  end

  // Core state: frequency tracking, accumulator, frame counter, error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freq_reg_r     <= {FREQ_W{1'b0}};
      acc_r          <= {FREQ_W{1'b0}};
      idx_cnt_r      <= 8'd0;
      first_strobe_r <= 1'b1;
      freq_err_r     <= 1'b0;
    end else begin
      if (freq_chg_s) begin
        freq_reg_r <= freq_hz;
      end else begin
        freq_reg_r <= freq_reg_r;
      end
      acc_r          <= acc_nxt_s;
      idx_cnt_r      <= idx_nxt_s;
      first_strobe_r <= first_nxt_s;
      freq_err_r     <= freq_err_nxt_s;
    end
  end

  // Registered strobe outputs; sample_idx holds between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      audio_sample_r <= 1'b0;
      sample_idx_r   <= 8'd0;
      block_start_r  <= 1'b0;
    end else begin
      audio_sample_r <= wrap_s;
      block_start_r  <= wrap_s && (cur_idx_s == 8'd0);
      if (wrap_s) begin
        sample_idx_r <= cur_idx_s;
      end else begin
        sample_idx_r <= sample_idx_r;
      end
    end
  end

  assign audio_sample = audio_sample_r;
  assign sample_idx   = sample_idx_r;
  assign block_start  = block_start_r;
  assign freq_err     = freq_err_r;

endmodule

// File: tb/tb_audio_sample_strobe_gen.sv
// Self-checking bench for audio_sample_strobe_gen. The reference model counts
// accumulator updates n since the last phase restart and predicts a strobe
// whenever floor(n*SR/F) steps up; frame indices are strobe counts mod 192.
module tb_audio_sample_strobe_gen;

  localparam longint SR = 48000;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [27:0] freq_hz;
  logic        audio_sample;
  logic [7:0]  sample_idx;
  logic        block_start;
  logic        freq_err;

  int n_assert;
  int n_fail;

  // Reference model state
  logic [27:0] m_freq;
  bit          m_err;
  longint      m_n;
  int          m_cnt;
  int          m_idx;
  bit          m_strobe;
  bit          m_bs;
  int          cyc;

  audio_sample_strobe_gen dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .freq_hz      (freq_hz),
    .audio_sample (audio_sample),
    .sample_idx   (sample_idx),
    .block_start  (block_start),
    .freq_err     (freq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_freq = 28'd0; m_err = 1'b0; m_n = 0; m_cnt = 0;
    m_idx = 0; m_strobe = 1'b0; m_bs = 1'b0;
  endtask

  // One clock: advance the model from the inputs seen at the edge, then
  // compare all outputs 1 ns after the edge.
  task automatic tick();
    bit chg, run, exp_s, err_nxt;
    longint f;
    @(posedge clk);
    cyc++;
    chg = (freq_hz != m_freq);
    run = enable && !m_err && !chg;
    f = longint'(m_freq);
    exp_s = 1'b0;
    if (run) begin
      if (f == 0) exp_s = 1'b1;
      else exp_s = (((m_n + 1) * SR) / f) > ((m_n * SR) / f);
    end
    err_nxt = (f < 2 * SR);
    if (chg) begin
      m_freq = freq_hz; m_n = 0;
    end else if (run) begin
      m_n++;
    end else begin
      m_n = 0;
    end
    m_strobe = exp_s;
    m_bs = 1'b0;
    if (exp_s) begin
      m_idx = m_cnt;
      m_bs  = (m_cnt == 0);
      m_cnt = (m_cnt + 1) % 192;
    end
    if (!enable) m_cnt = 0;
    m_err = err_nxt;
    #1;
    chk("audio_sample", audio_sample, m_strobe);
    chk("block_start", block_start, m_bs);
    chk("sample_idx", sample_idx, m_idx);
    chk("freq_err", freq_err, m_err);
  endtask

  initial begin
    int k, cnt, last, iv, bad, bs_cnt, wraps, prev_idx;
    bit hist[2500];
    n_assert = 0; n_fail = 0; cyc = 0;
    reset_n = 1'b0; enable = 1'b0; freq_hz = 28'd0;
    model_reset();
    #12;
    chk("rst_audio_sample", audio_sample, 0);
    chk("rst_block_start", block_start, 0);
    chk("rst_sample_idx", sample_idx, 0);
    chk("rst_freq_err", freq_err, 0);
    reset_n = 1'b1;

    // 192 kHz: strobe every 4 clocks, first after 4 updates
    freq_hz = 28'd192000;
    repeat (3) tick();
    enable = 1'b1;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); k++;
      if (audio_sample) break;
    end
    chk("first_latency", k, 4);
    cnt = 0; last = cyc; bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (audio_sample) begin
        cnt++;
        if (cyc - last != 4) bad++;
        last = cyc;
      end
    end
    chk("s192_count", cnt, 10);
    chk("s192_interval", bad, 0);

    // 200 kHz: 600 strobes in 2500 updates, 4/5 spacing, 25-clock period
    freq_hz = 28'd200000;
    tick();
    cnt = 0; last = -1; bad = 0;
    for (int i = 0; i < 2500; i++) begin
      tick();
      hist[i] = audio_sample;
      if (audio_sample) begin
        cnt++;
        if (last >= 0) begin
          iv = cyc - last;
          if (iv != 4 && iv != 5) bad++;
        end
        last = cyc;
      end
    end
    chk("s200_count", cnt, 600);
    chk("s200_interval", bad, 0);
    bad = 0; cnt = 0;
    for (int i = 0; i < 2475; i++) if (hist[i] != hist[i + 25]) bad++;
    for (int i = 0; i < 25; i++) if (hist[i]) cnt++;
    chk("s200_period", bad, 0);
    chk("s200_per25", cnt, 6);

    // Unusable frequencies, then the minimum usable one
    freq_hz = 28'd95999;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (audio_sample) cnt++; end
    chk("err95999_flag", freq_err, 1);
    freq_hz = 28'd0;
    for (int i = 0; i < 6; i++) begin tick(); if (audio_sample) cnt++; end
    chk("err0_flag", freq_err, 1);
    chk("err_no_strobe", cnt, 0);
    freq_hz = 28'd96000;
    repeat (4) tick();
    chk("f96k_err_clear", freq_err, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (audio_sample) cnt++; end
    chk("f96k_count", cnt, 10);
    bs_cnt = 0; wraps = 0; prev_idx = sample_idx;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (audio_sample) begin
        if (block_start) bs_cnt++;
        if (prev_idx == 191 && sample_idx == 0) wraps++;
        prev_idx = sample_idx;
      end
    end
    chk("block_wraps", wraps, bs_cnt);
    chk("block_wrap_seen", (wraps >= 1) ? 1 : 0, 1);

    // Frequency step on the very cycle a wrap is due
    freq_hz = 28'd192000;
    k = 0;
    for (int i = 0; i < 20; i++) begin tick(); k++; if (audio_sample && k > 2) break; end
    chk("step_sync", audio_sample, 1);
    repeat (3) tick();
    freq_hz = 28'd144000;
    tick();
    chk("step_no_strobe", audio_sample, 0);
    k = 0;
    for (int i = 0; i < 10; i++) begin tick(); k++; if (audio_sample) break; end
    chk("step_next_latency", k, 3);

    // Enable low for 10 clocks, then restart from frame 0
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (audio_sample) cnt++; end
    chk("disabled_no_strobe", cnt, 0);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); if (audio_sample) break; end
    chk("reenable_strobe", audio_sample, 1);
    chk("reenable_idx", sample_idx, 0);
    chk("reenable_block_start", block_start, 1);

    // 28 MHz system clock: spacing 583/584, first after 584 updates
    freq_hz = 28'd28000000;
    tick();
    cnt = 0; last = cyc; bad = 0; k = -1;
    for (int i = 0; i < 30000; i++) begin
      tick();
      if (audio_sample) begin
        iv = cyc - last;
        if (k < 0) k = iv;
        else if (iv != 583 && iv != 584) bad++;
        cnt++;
        last = cyc;
      end
    end
    chk("s28m_first", k, 584);
    chk("s28m_interval", bad, 0);
    chk("s28m_count", cnt, 51);

    // Randomised frequency steps and enable toggles
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199, 0) == 0) begin
        if ($urandom_range(9, 0) == 0) freq_hz = 28'($urandom_range(95999, 0));
        else freq_hz = 28'($urandom_range(600000, 96000));
      end
      if ($urandom_range(99, 0) == 0) enable = ~enable;
      tick();
    end

    // Asynchronous reset in the middle of a strobe cycle
    enable = 1'b1;
    freq_hz = 28'd96000;
    k = 0;
    for (int i = 0; i < 20; i++) begin tick(); k++; if (audio_sample && k > 3) break; end
    chk("pre_reset_strobe", audio_sample, 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_audio_sample", audio_sample, 0);
    chk("async_rst_block_start", block_start, 0);
    chk("async_rst_sample_idx", sample_idx, 0);
    chk("async_rst_freq_err", freq_err, 0);
    model_reset();
    #2;
    reset_n = 1'b1;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
